alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Registered execute stage directly downstream of the ALU operand/opcode selection logic.
- Consumes the selected operands a/b, the carry-in, the 4-bit ALU opcode and the carry/overflow store enables.
- Computes the result and holds it in a one-entry output register with a valid/ready handshake.
- Owns the architectural carry and overflow flag registers that feed back to operand selection (carry-in for CARRY/BORROW) and to conditional branch evaluation.

Parameters:
WORD_WIDTH, 32, datapath width in bits; must be a power of two and at least 8.

Ports:
clk  input  1  clock; all state is rising-edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  operand bundle present.
in_ready  output  1  stage can accept a bundle this cycle.
alu_a  input  WORD_WIDTH  operand A.
alu_b  input  WORD_WIDTH  operand B; also the shift amount for shift ops.
alu_ic  input  1  carry-in for OP_ADD; ignored by all other ops (may be X).
alu_opcode  input  4  ALU opcode from the shared opcode defines.
store_carry  input  1  commit the computed carry into the carry flag on accept.
store_overflow  input  1  commit the computed overflow into the overflow flag on accept.
flush  input  1  synchronous discard of held result; no input accepted this cycle.
out_valid  output  1  result register holds a valid result.
out_ready  input  1  consumer takes the result this cycle.
result  output  WORD_WIDTH  registered result.
carry  output  1  architectural carry flag.
overflow  output  1  architectural overflow flag.

Behaviour:
- Reset (async, active-high): out_valid=0, result=0, carry=0, overflow=0. in_ready is 0 while reset is asserted.
- in_ready = !reset && !flush && (!out_valid || out_ready). This is combinational and supports full throughput: back-to-back accepts every cycle while out_ready=1.
- Accept condition: in_valid && in_ready. On an accepted cycle the following are visible at the next edge:
  - result and out_valid=1.
  - flag updates.
  - Latency is 1 cycle.
- Pop without accept: if out_valid && out_ready && !accept, then out_valid becomes 0. result holds its last value.
- Stall: if out_valid && !out_ready, result, out_valid and the flags hold. Inputs are not accepted.
- flush: out_valid becomes 0 next cycle. Flags are untouched. flush beats in_valid in the same cycle, and the bundle is not accepted.
- OP_ADD: {c, r} = a + b + ic, computed at WORD_WIDTH+1 bits.
  - c is the carry-out.
  - ov = (a[MSB]==b[MSB]) && (r[MSB]!=a[MSB]).
- OP_AND, OP_OR, OP_XOR: bitwise. c=0, ov=0.
- Shifts: amount = b, treated as unsigned.
  - OP_LSL, OP_LSR: zero-fill. If amount >= WORD_WIDTH, the result is 0.
  - OP_ASR: sign-fill. If amount >= WORD_WIDTH, the result is all copies of a[MSB].
  - OP_CSL, OP_CSR: rotate by amount mod WORD_WIDTH. An amount of 0 returns a.
  - All shifts produce c=0, ov=0.
- OP_NOP and any undefined opcode: r=0, c=0, ov=0. The stage still produces a valid output.
- Flags: on accept, carry <= c if store_carry, and overflow <= ov if store_overflow. Each enable is independent. Flags never change without an accept.
- Flag hazard: the carry output reflects an update only from the cycle after the accept; there is no internal bypass. The issuing logic is responsible for not issuing a dependent CARRY/BORROW in the same cycle.
- Reset mid-operation: the held result is lost and the flags clear. The first accept after reset deassertion is permitted on the first clock edge at which reset is low.

Decomposition:
- Opcode encodings (OP_ADD, OP_AND, OP_OR, OP_XOR, OP_LSL, OP_LSR, OP_CSL, OP_CSR, OP_ASR, OP_NOP) come from the shared ALU opcode definitions. This block defines no new encodings.
- One combinational sub-module, alu_core: inputs a, b, ic, opcode; outputs r, c, ov. It is parameterised by WORD_WIDTH and reused by any future unregistered path.
- alu_exec_stage contains only the handshake, the result register and the flag registers.

Test Plan:
- ADD a=0xFFFFFFFF, b=0x00000001, ic=0, store_carry=store_overflow=1 -> next cycle: result=0, carry=1, overflow=0, out_valid=1.
- ADD a=0x7FFFFFFF, b=0, ic=1, store_overflow=1, store_carry=0 (carry pre-set to 1) -> result=0x80000000, overflow=1, carry stays 1.
- Shifts with a=0x80000001:
  - LSL b=33 -> result=0.
  - ASR b=40 -> result=0xFFFFFFFF.
  - CSL b=33 -> result=0x00000003.
  - CSR b=1 -> result=0xC0000000.
- Backpressure: accept XOR 0xF0F0F0F0^0xFFFFFFFF, then out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and result=0x0F0F0F0F held. After out_ready=1, the next bundle is accepted that same cycle, and out_valid stays 1.
- flush with in_valid=1 and out_valid=1 -> bundle not accepted, out_valid=0 next cycle, flags unchanged.
- Assert reset while out_valid=1 and carry=1 -> out_valid, result, carry and overflow are 0 immediately, without waiting for a clock edge. The first bundle after reset release is accepted and appears 1 cycle later.

Source files
------------

// File: rtl/alu_exec_stage_pkg.sv
// Shared ALU opcode encodings and small helpers for the execute stage.
package alu_exec_stage_pkg;

   typedef logic [3:0] alu_opcode_t;

   localparam alu_opcode_t OP_NOP = 4'h0;
   localparam alu_opcode_t OP_ADD = 4'h1;
   localparam alu_opcode_t OP_AND = 4'h2;
   localparam alu_opcode_t OP_OR  = 4'h3;
   localparam alu_opcode_t OP_XOR = 4'h4;
   localparam alu_opcode_t OP_LSL = 4'h5;
   localparam alu_opcode_t OP_LSR = 4'h6;
   localparam alu_opcode_t OP_ASR = 4'h7;
   localparam alu_opcode_t OP_CSL = 4'h8;
   localparam alu_opcode_t OP_CSR = 4'h9;

   // Signed overflow of an add: operands agree in sign, result does not.
   function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic r_msb);
      return (a_msb == b_msb) && (r_msb != a_msb);
   endfunction

endpackage

// File: rtl/alu_exec_stage_alu_core.sv
// Combinational ALU: result, carry-out and overflow for one opcode/operand set.
import alu_exec_stage_pkg::*;

module alu_core #(
   parameter int WORD_WIDTH = 32
) (
   input  logic [WORD_WIDTH-1:0] a,
   input  logic [WORD_WIDTH-1:0] b,
   input  logic                  ic,
   input  alu_opcode_t           opcode,
   output logic [WORD_WIDTH-1:0] r,
   output logic                  c,
   output logic                  ov
);

   localparam int SHW = $clog2(WORD_WIDTH);

   logic [SHW-1:0]      amt;
   logic [SHW:0]        amt_rev;
   logic                big;
   logic [WORD_WIDTH:0] sum;

   // WORD_WIDTH is a power of two, so any set bit above the low SHW bits means amount >= width.
   assign amt     = b[SHW-1:0];
   assign big     = |b[WORD_WIDTH-1:SHW];
   assign amt_rev = (SHW+1)'(WORD_WIDTH) - {1'b0, amt};
   assign sum     = {1'b0, a} + {1'b0, b} + {{WORD_WIDTH{1'b0}}, ic};

   always_comb begin
      r  = '0;
      c  = 1'b0;
      ov = 1'b0;
      case (opcode)
         OP_ADD: begin
            r  = sum[WORD_WIDTH-1:0];
            c  = sum[WORD_WIDTH];
            ov = add_overflow(a[WORD_WIDTH-1], b[WORD_WIDTH-1], sum[WORD_WIDTH-1]);
         end
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         OP_LSL: r = big ? '0 : (a << amt);
         OP_LSR: r = big ? '0 : (a >> amt);
         OP_ASR: r = big ? {WORD_WIDTH{a[WORD_WIDTH-1]}} : $unsigned($signed(a) >>> amt);
         // amt_rev equals WORD_WIDTH when amt is 0, shifting the wrap term out entirely.
         OP_CSL: r = (a << amt) | (a >> amt_rev);
         OP_CSR: r = (a >> amt) | (a << amt_rev);
         default: r = '0;
      endcase
   end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: valid/ready output register plus carry/overflow flags.
import alu_exec_stage_pkg::*;

module alu_exec_stage #(
   parameter int WORD_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WORD_WIDTH-1:0] alu_a,
   input  logic [WORD_WIDTH-1:0] alu_b,
   input  logic                  alu_ic,
   input  logic [3:0]            alu_opcode,
   input  logic                  store_carry,
   input  logic                  store_overflow,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WORD_WIDTH-1:0] result,
   output logic                  carry,
   output logic                  overflow
);

   logic [WORD_WIDTH-1:0] core_r;
   logic                  core_c;
   logic                  core_ov;
   logic                  accept;

   alu_core #(
      .WORD_WIDTH(WORD_WIDTH)
   ) u_alu_core (
      .a      (alu_a),
      .b      (alu_b),
      .ic     (alu_ic),
      .opcode (alu_opcode),
      .r      (core_r),
      .c      (core_c),
      .ov     (core_ov)
   );

   assign in_ready = !reset && !flush && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         result    <= '0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         result    <= core_r;
         if (store_carry)    carry    <= core_c;
         if (store_overflow) overflow <= core_ov;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: vector table through a scoreboard, then handshake corner sequences.
import alu_exec_stage_pkg::*;

module tb_alu_exec_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic        alu_ic;
   logic [3:0]  alu_opcode;
   logic        store_carry;
   logic        store_overflow;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        carry;
   logic        overflow;

   alu_exec_stage #(.WORD_WIDTH(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .alu_a          (alu_a),
      .alu_b          (alu_b),
      .alu_ic         (alu_ic),
      .alu_opcode     (alu_opcode),
      .store_carry    (store_carry),
      .store_overflow (store_overflow),
      .flush          (flush),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .result         (result),
      .carry          (carry),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        ic;
      logic        sc;
      logic        so;
      logic [31:0] r;
      logic        c;
      logic        ov;
   } vec_t;

   typedef struct {
      logic [31:0] r;
      logic        c;
      logic        ov;
   } exp_t;

   vec_t  vecs[$];
   exp_t  sbq[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   logic [31:0] cur_r;
   logic        cur_c, cur_ov;
   logic        mc, mov;

   function automatic vec_t mk(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic ic,
                               logic sc, logic so, logic [31:0] r, logic c, logic ov);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.ic = ic; v.sc = sc; v.so = so;
      v.r = r; v.c = c; v.ov = ov;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_in(vec_t v, logic vld);
      in_valid       = vld;
      alu_opcode     = v.op;
      alu_a          = v.a;
      alu_b          = v.b;
      alu_ic         = v.ic;
      store_carry    = v.sc;
      store_overflow = v.so;
      cur_r          = v.r;
      cur_c          = v.c;
      cur_ov         = v.ov;
   endtask

   // Scoreboard work at the falling edge, then advance to just after the next rising edge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (reset) begin
         sbq.delete();
         mc  = 1'b0;
         mov = 1'b0;
      end else begin
         if (out_valid && flush) begin
            if (sbq.size() > 0) void'(sbq.pop_front());
         end else if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               chk("unexpected_output", 32'd1, 32'd0);
            end else begin
               e = sbq.pop_front();
               chk("result", result, e.r);
               chk("carry", {31'd0, carry}, {31'd0, e.c});
               chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
            end
         end
         if (in_valid && in_ready) begin
            if (store_carry)    mc  = cur_c;
            if (store_overflow) mov = cur_ov;
            e.r = cur_r; e.c = mc; e.ov = mov;
            sbq.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs.push_back(mk(OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0));
      vecs.push_back(mk(OP_ADD, 32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1));
      vecs.push_back(mk(OP_AND, 32'hF0F0F0F0, 32'h3C3C3C3C, 1'b1, 1'b1, 1'b1, 32'h30303030, 1'b0, 1'b0));
      vecs.push_back(mk(OP_OR,  32'h12340000, 32'h00005678, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0));
      vecs.push_back(mk(OP_XOR, 32'hF0F0F0F0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h0F0F0F0F, 1'b0, 1'b0));
      vecs.push_back(mk(OP_LSL, 32'h80000001, 32'd33, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0));
      vecs.push_back(mk(OP_ASR, 32'h80000001, 32'd40, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0));
      vecs.push_back(mk(OP_CSL, 32'h80000001, 32'd33, 1'b0, 1'b0, 1'b0, 32'h00000003, 1'b0, 1'b0));
      vecs.push_back(mk(OP_CSR, 32'h80000001, 32'd1,  1'b0, 1'b0, 1'b0, 32'hC0000000, 1'b0, 1'b0));
      vecs.push_back(mk(OP_LSL, 32'h80000001, 32'd4,  1'b0, 1'b0, 1'b0, 32'h00000010, 1'b0, 1'b0));
      vecs.push_back(mk(OP_LSR, 32'h80000001, 32'd31, 1'b0, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b0));
      vecs.push_back(mk(OP_LSR, 32'h80000001, 32'd32, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0));
      vecs.push_back(mk(OP_ASR, 32'h80000001, 32'd4,  1'b0, 1'b0, 1'b0, 32'hF8000000, 1'b0, 1'b0));
      vecs.push_back(mk(OP_ASR, 32'h40000000, 32'd40, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0));
      vecs.push_back(mk(OP_CSL, 32'h12345678, 32'd0,  1'b0, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0));
      vecs.push_back(mk(OP_CSR, 32'h12345678, 32'd32, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0));
      vecs.push_back(mk(OP_CSR, 32'h12345678, 32'd4,  1'b0, 1'b0, 1'b0, 32'h81234567, 1'b0, 1'b0));
      vecs.push_back(mk(OP_ADD, 32'h80000000, 32'h80000000, 1'b0, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b1));
      vecs.push_back(mk(OP_ADD, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 1'b0, 32'h00000003, 1'b0, 1'b0));
      vecs.push_back(mk(OP_NOP, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0));
      vecs.push_back(mk(4'hF,   32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b1, 1'b1, 32'h00000000, 1'b0, 1'b0));

      mc = 1'b0; mov = 1'b0;
      reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
      set_in(vecs[0], 1'b0);
      #3;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_carry", {31'd0, carry}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Back-to-back table run at full throughput.
      foreach (vecs[i]) begin
         set_in(vecs[i], 1'b1);
         #1;
         chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
         tick();
      end
      in_valid = 1'b0;
      tick();
      tick();
      chk("drain_empty", sbq.size(), 32'd0);

      // Backpressure: XOR held for 3 stalled cycles, then next bundle accepted on release.
      out_ready = 1'b0;
      set_in(vecs[4], 1'b1);
      tick();
      set_in(mk(OP_ADD, 32'd5, 32'd6, 1'b0, 1'b0, 1'b0, 32'd11, 1'b0, 1'b0), 1'b1);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
         chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_result", result, 32'h0F0F0F0F);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("release_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      #1;
      chk("release_out_valid", {31'd0, out_valid}, 32'd1);
      chk("release_result", result, 32'd11);
      tick();
      tick();

      // Flush beats in_valid; held result dropped, flags untouched.
      out_ready = 1'b0;
      set_in(vecs[0], 1'b1);
      tick();
      set_in(mk(OP_ADD, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0), 1'b1);
      flush = 1'b1;
      #1;
      chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_carry", {31'd0, carry}, 32'd1);
      chk("flush_overflow", {31'd0, overflow}, 32'd0);
      chk("flush_sb_empty", sbq.size(), 32'd0);
      tick();

      // Asynchronous reset while a result with both flags set is held.
      set_in(mk(OP_ADD, 32'h80000001, 32'h80000000, 1'b0, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b1), 1'b1);
      tick();
      in_valid = 1'b0;
      #1;
      chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
      chk("pre_rst_carry", {31'd0, carry}, 32'd1);
      chk("pre_rst_overflow", {31'd0, overflow}, 32'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("async_rst_result", result, 32'd0);
      chk("async_rst_carry", {31'd0, carry}, 32'd0);
      chk("async_rst_overflow", {31'd0, overflow}, 32'd0);
      chk("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      reset = 1'b0;
      out_ready = 1'b1;
      set_in(mk(OP_OR, 32'h00000F00, 32'h000000F0, 1'b0, 1'b1, 1'b1, 32'h00000FF0, 1'b0, 1'b0), 1'b1);
      #1;
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      #1;
      chk("post_rst_out_valid", {31'd0, out_valid}, 32'd1);
      chk("post_rst_result", result, 32'h00000FF0);
      tick();
      tick();
      chk("final_sb_empty", sbq.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
